// File: rtl/fft_pipe_seq_if.sv
// Handshake and control bundle between the FFT datapath sequencer and
// the blocks it steers (Blq commutators, coefficient memories, output stage).
interface fft_pipe_seq_if #(
  parameter int CNT_W = 5
) ();

  logic             i_valid;
  logic             i_last;
  logic             o_ready;
  logic             o_ce;
  logic [CNT_W-1:0] o_coeff0_idx;
  logic [CNT_W-1:0] o_coeff1_idx;
  logic             o_blq_ctrl;
  logic             o_enable;
  logic             o_busy;

  // The sample source drives the beat qualifiers and observes the controls.
  modport master (
    output i_valid,
    output i_last,
    input  o_ready,
    input  o_ce,
    input  o_coeff0_idx,
    input  o_coeff1_idx,
    input  o_blq_ctrl,
    input  o_enable,
    input  o_busy
  );

  // The sequencer consumes the beat qualifiers and produces the controls.
  modport slave (
    input  i_valid,
    input  i_last,
    output o_ready,
    output o_ce,
    output o_coeff0_idx,
    output o_coeff1_idx,
    output o_blq_ctrl,
    output o_enable,
    output o_busy
  );

endinterface

// File: rtl/fft_pipe_seq.sv
// Sequencer for the two-stage parallel FFT datapath. Counts accepted input
// beats, produces the shared clock-enable, steps the stage-I and stage-II
// coefficient indices, toggles the Blq commutator select and flags valid
// output beats. A cycle without clock-enable freezes every register.
module fft_pipe_seq #(
  parameter int N     = 32,
  parameter int DELAY = 16,
  parameter int CNT_W = $clog2(N),
  parameter int DLY_W = $clog2(DELAY) + 1
) (
  input  logic              clk,
  input  logic              rst,
  fft_pipe_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY - 1);

  state_t           state;
  state_t           state_n;
  logic             ce;
  logic             ready;
  logic             accept;
  logic             last_acc;
  logic [CNT_W-1:0] coeff0_idx;
  logic [CNT_W-1:0] coeff1_idx;
  logic [DLY_W-1:0] fill_cnt;
  logic [DLY_W-1:0] drain_cnt;
  logic [DLY_W-1:0] blq_cnt;
  logic             blq_ctrl;

  function automatic logic [CNT_W-1:0] idx_inc(input logic [CNT_W-1:0] v);
    return (v == IDX_LAST) ? '0 : v + CNT_W'(1);
  endfunction

  // State register; reset discards any frame in progress without draining.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Beat qualification and next state; i_last outranks the fill-complete exit.
  always_comb begin
    state_n  = state;
    ready    = (state != DRAIN);
    ce       = (state == DRAIN) ? 1'b1 : bus.i_valid;
    accept   = bus.i_valid & ready;
    last_acc = accept & bus.i_last;
    case (state)
      IDLE: begin
        if (accept) state_n = last_acc ? DRAIN : FILL;
      end
      FILL: begin
        if (last_acc)                             state_n = DRAIN;
        else if (accept && fill_cnt == DLY_LAST)  state_n = RUN;
      end
      RUN: begin
        if (last_acc) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DLY_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Beat-driven counters and indices; everything returns to zero on entry to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      coeff0_idx <= '0;
      coeff1_idx <= '0;
      fill_cnt   <= '0;
      drain_cnt  <= '0;
      blq_cnt    <= '0;
      blq_ctrl   <= 1'b0;
    end else if (ce) begin
      if (state_n == IDLE) begin
        coeff0_idx <= '0;
        coeff1_idx <= '0;
        fill_cnt   <= '0;
        drain_cnt  <= '0;
        blq_cnt    <= '0;
        blq_ctrl   <= 1'b0;
      end else begin
        coeff0_idx <= idx_inc(coeff0_idx);
        if (state == RUN || state == DRAIN) coeff1_idx <= idx_inc(coeff1_idx);
        if (blq_cnt == DLY_LAST) begin
          blq_cnt  <= '0;
          blq_ctrl <= ~blq_ctrl;
        end else begin
          blq_cnt  <= blq_cnt + DLY_W'(1);
        end
        if (state == IDLE)      fill_cnt <= DLY_W'(1);
        else if (state == FILL) fill_cnt <= fill_cnt + DLY_W'(1);
        if (state == DRAIN) drain_cnt <= drain_cnt + DLY_W'(1);
        else                drain_cnt <= '0;
      end
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_ce         = ce;
  assign bus.o_coeff0_idx = coeff0_idx;
  assign bus.o_coeff1_idx = coeff1_idx;
  assign bus.o_blq_ctrl   = blq_ctrl;
  assign bus.o_enable     = ce & (state == RUN || state == DRAIN);
  assign bus.o_busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_pipe_seq.sv
// Scoreboard bench for fft_pipe_seq. The reference model tracks a frame as
// plain beat counts: total beats taken, output beats produced and drain
// progress; expected indices follow directly from those counts.
module tb_fft_pipe_seq;

  localparam int N     = 32;
  localparam int DELAY = 16;
  localparam int CNT_W = 5;
  localparam int DLY_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_pipe_seq_if #(.CNT_W(CNT_W)) bus ();

  fft_pipe_seq #(
    .N(N),
    .DELAY(DELAY),
    .CNT_W(CNT_W),
    .DLY_W(DLY_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             ce;
    logic             ready;
    logic             enable;
    logic             busy;
    logic             blq;
    logic [CNT_W-1:0] c0;
    logic [CNT_W-1:0] c1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  bit m_active   = 1'b0;
  bit m_draining = 1'b0;
  int m_total    = 0;
  int m_outs     = 0;
  int m_drain    = 0;

  function automatic exp_t model_out(input bit v);
    exp_t e;
    e.busy   = m_active;
    e.ready  = !m_draining;
    e.ce     = m_draining ? 1'b1 : v;
    e.enable = e.ce && (m_draining || m_total >= DELAY);
    e.c0     = CNT_W'(m_total % N);
    e.c1     = CNT_W'(m_outs % N);
    e.blq    = ((m_total / DELAY) % 2) != 0;
    return e;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_draining = 1'b0;
    m_total    = 0;
    m_outs     = 0;
    m_drain    = 0;
  endtask

  task automatic model_step(input bit v, input bit l);
    exp_t e;
    e = model_out(v);
    if (e.ce) begin
      m_total++;
      if (e.enable) m_outs++;
      if (m_draining) begin
        m_drain++;
        if (m_drain == DELAY) model_reset();
      end else begin
        m_active = 1'b1;
        if (l) begin
          m_draining = 1'b1;
          m_drain    = 0;
        end
      end
    end
  endtask

  task automatic check_field(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic checkOutput(input exp_t e);
    check_field("o_ce",         int'(bus.o_ce),         int'(e.ce));
    check_field("o_ready",      int'(bus.o_ready),      int'(e.ready));
    check_field("o_enable",     int'(bus.o_enable),     int'(e.enable));
    check_field("o_busy",       int'(bus.o_busy),       int'(e.busy));
    check_field("o_blq_ctrl",   int'(bus.o_blq_ctrl),   int'(e.blq));
    check_field("o_coeff0_idx", int'(bus.o_coeff0_idx), int'(e.c0));
    check_field("o_coeff1_idx", int'(bus.o_coeff1_idx), int'(e.c1));
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what the model predicts.
  task automatic applyStimulus(input bit v, input bit l, input bit r, input bit track);
    @(posedge clk);
    #1;
    bus.i_valid = v;
    bus.i_last  = l;
    rst         = r;
    if (track) exp_q.push_back(model_out(v));
    if (r) model_reset();
    else   model_step(v, l);
  endtask

  // Feed one frame of len accepted beats; stall_mode 0 none, 1 every third cycle, 2 random.
  task automatic run_frame(input int len, input int stall_mode, input int rst_beat);
    int beats;
    int cyc;
    bit v;
    bit l;
    bit r;
    beats = 0;
    cyc   = 0;
    while (beats < len && cyc < 10 * len + 10) begin
      case (stall_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3) != 2;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      l = v && (beats + 1 == len);
      r = v && (rst_beat != 0) && (beats + 1 == rst_beat);
      applyStimulus(v, l, r, 1'b1);
      if (v) beats++;
      cyc++;
      if (r) break;
    end
  endtask

  // Let the drain finish with junk traffic offered while not ready, then idle.
  task automatic drain_out();
    bit v;
    bit l;
    for (int i = 0; i < DELAY + 3; i++) begin
      v = m_draining ? 1'($urandom_range(0, 1)) : 1'b0;
      l = v ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(v, l, 1'b0, 1'b1);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare queued expectations against the DUT away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(2);

    $display("[TB] 40-beat frame, no stalls");
    run_frame(40, 0, 0);
    drain_out();

    $display("[TB] 40-beat frame, stall every third cycle");
    run_frame(40, 1, 0);
    drain_out();

    $display("[TB] early last inside fill");
    run_frame(5, 0, 0);
    drain_out();

    $display("[TB] single beat frame");
    run_frame(1, 0, 0);
    drain_out();

    $display("[TB] reset mid-run, then fresh frame");
    run_frame(40, 0, 25);
    idle_cycles(2);
    run_frame(30, 0, 0);
    drain_out();

    $display("[TB] 100-beat frame for index wrap");
    run_frame(100, 0, 0);
    drain_out();

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 70), 2, 0);
      drain_out();
      idle_cycles($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
